tag_dual_snoop_q: RTL and testbench
===================================

// Module: tag_dual_snoop_q
// PURPOSE
//  Dual-bank D-cache tag store with a queued snoop port, for the dual-core coherence path.
//  Bank 0 serves the local pipeline (port A) and the fill/victim path (port B).
//  Bank 1 is a mirror that every port-A/B write also updates; its port A is free for snoop lookups.
//  Snoops are buffered in a FIFO and issue only in cycles free of port-A writes.
//  A starvation limiter stalls port A so that snoops cannot be locked out.
// PARAMETERS
//  WIDTH         32   tag entry width in bits ($bits(dtag_entry_t) at instantiation)
//  LINES         512  tag lines; address width AW = $clog2(LINES)
//  SNOOP_DEPTH   4    snoop request FIFO entries; power of 2, >= 2
//  STARVE_LIMIT  8    consecutive blocked cycles with a pending snoop before port A is stalled
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  en_a         in   1      port A access enable
//  wen_a        in   1      port A write enable (qualified by en_a)
//  addr_a       in   AW     port A line address
//  data_in_a    in   WIDTH  port A write data
//  data_out_a   out  WIDTH  port A read data, 1-cycle latency
//  stall_a      out  1      port A access this cycle is dropped; the requester must hold and retry
//  en_b         in   1      port B enable
//  wen_b        in   1      port B write enable
//  addr_b       in   AW     port B line address
//  data_in_b    in   WIDTH  port B write data
//  data_out_b   out  WIDTH  port B read data, 1-cycle latency
//  snp_valid    in   1      snoop request valid
//  snp_ready    out  1      FIFO not full; request accepted when snp_valid & snp_ready
//  snp_addr     in   AW     snoop line address
//  snp_id       in   2      requester tag, returned with the response
//  snp_rsp_valid out 1      snoop response valid (one-cycle pulse)
//  snp_rsp_addr out  AW     address of the response
//  snp_rsp_id   out  2      id of the response
//  snp_rsp_data out  WIDTH  tag entry read from bank 1
// BEHAVIOUR
//  Reset values:
//   - all outputs are 0 except snp_ready = 1
//   - FIFO empty, starve_cnt = 0, issue stage idle; RAM contents are not reset
//  Write mirroring:
//   - a port-A write (en_a & wen_a & !stall_a) writes bank 0 port A and bank 1 port A at addr_a
//   - a port-B write writes bank 0 port B and bank 1 port B at addr_b
//  Snoop issue:
//   - issue when FIFO non-empty and no port-A write is performed this cycle
//   - on issue: pop the head and read bank 1 port A at the head address
//   - next cycle: snp_rsp_valid = 1 with the captured addr/id and snp_rsp_data
//  Starvation:
//   - starve_cnt increments each cycle the FIFO is non-empty and the issue is blocked by a port-A write
//   - starve_cnt clears on any issue or when the FIFO is empty
//   - when starve_cnt == STARVE_LIMIT: stall_a = 1 combinationally for that cycle
//   - in that cycle the port-A access (read or write) is suppressed on both banks, the snoop issues, and starve_cnt clears
//   - data_out_a is undefined on the cycle after a stalled access
//  Same-cycle hazards:
//   - a snoop to an address written in cycle N, issued in cycle N+1 or later, returns the new data
//   - a port-A and port-B write to the same address in the same cycle: port B wins in both banks, so the banks stay identical
//  FIFO:
//   - snp_ready = !full (registered count)
//   - push and pop in the same cycle while full is not allowed, since ready = 0 blocks the push
//   - push and pop in the same cycle while non-full keeps the count unchanged
//   - head/tail pointers wrap modulo SNOOP_DEPTH
//   - the response order equals the acceptance order
//  Reset asserted mid-operation: FIFO is flushed, in-flight responses are dropped, and snp_rsp_valid deasserts asynchronously.
// STRUCTURE
//  - taiga_types gains snoop_req_t {addr, id} and snoop_rsp_t {addr, id, data}
//  - taiga_config gains SNOOP_DEPTH and SNOOP_STARVE_LIMIT
//  - reuse the existing tag_bank twice: bank 0 and mirror bank 1
//  - new sub-module snoop_req_fifo: parametrised SNOOP_DEPTH, count-based full/empty
//  - top level holds the issue arbiter, starve counter and response register
// TESTING
//  1. Reset, then write 0xA5A5_0001 to line 3 via port A; snoop line 3 -> rsp 2 cycles after accept, data 0xA5A5_0001, id echoed.
//  2. Port A writes every cycle, snoop pending, STARVE_LIMIT=8 -> stall_a pulses on the 9th blocked cycle, rsp follows, write retried.
//  3. Push 4 snoops (lines 1,2,3,4) with port A busy -> snp_ready = 0 after 4th; responses return in order 1,2,3,4.
//  4. Port B write line 7 = 0x1234 and port A write line 7 = 0x5678 in the same cycle -> port A read and snoop both give 0x1234.
//  5. Write line 9 in cycle N, snoop line 9 accepted in N -> issue in N+1, rsp data = new value; banks checked equal by backdoor.
//  6. rst_n low while FIFO holds 3 entries -> snp_rsp_valid = 0 immediately, snp_ready = 1, no responses after release.

Source files
------------

// File: rtl/tag_dual_snoop_q_pkg.sv
// Shared types and default configuration for the dual-bank D-cache tag store
// and its queued snoop port.
package tag_dual_snoop_q_pkg;

   localparam int CFG_LINES              = 512;
   localparam int CFG_AW                 = $clog2(CFG_LINES);
   localparam int CFG_SNOOP_DEPTH        = 4;
   localparam int CFG_SNOOP_STARVE_LIMIT = 8;
   localparam int SNOOP_ID_W             = 2;

   typedef struct packed {
      logic        valid;
      logic        dirty;
      logic [1:0]  state;
      logic [27:0] tag;
   } dtag_entry_t;

   typedef struct packed {
      logic [CFG_AW-1:0]     addr;
      logic [SNOOP_ID_W-1:0] id;
   } snoop_req_t;

   typedef struct packed {
      logic [CFG_AW-1:0]     addr;
      logic [SNOOP_ID_W-1:0] id;
      dtag_entry_t           data;
   } snoop_rsp_t;

endpackage

// File: rtl/snoop_req_fifo.sv
// Count-based snoop request FIFO; head entry is visible combinationally.
// Push is ignored while full and pop while empty.
module snoop_req_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/tag_bank.sv
// True dual-port tag RAM with registered 1-cycle reads.
// On a same-address write collision port B wins.
module tag_bank #(
   parameter int W     = 32,
   parameter int LINES = 512,
   parameter int AW    = $clog2(LINES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [W-1:0]  din_a,
   output logic [W-1:0]  dout_a,
   input  logic          en_b,
   input  logic          we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [W-1:0]  din_b,
   output logic [W-1:0]  dout_b
);

   logic [W-1:0] mem [LINES];

   // Port B is written last so it overrides port A on a collision.
   always_ff @(posedge clk) begin
      if (en_a && we_a) mem[addr_a] <= din_a;
      if (en_b && we_b) mem[addr_b] <= din_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_a <= '0;
         dout_b <= '0;
      end else begin
         if (en_a) dout_a <= mem[addr_a];
         if (en_b) dout_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/tag_dual_snoop_q.sv
// Dual-bank D-cache tag store: bank 0 serves ports A/B, bank 1 mirrors every
// write and lends its port A to queued snoop lookups when port A is not writing.
module tag_dual_snoop_q
   import tag_dual_snoop_q_pkg::*;
#(
   parameter int WIDTH        = $bits(dtag_entry_t),
   parameter int LINES        = CFG_LINES,
   parameter int SNOOP_DEPTH  = CFG_SNOOP_DEPTH,
   parameter int STARVE_LIMIT = CFG_SNOOP_STARVE_LIMIT,
   parameter int AW           = $clog2(LINES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_a,
   input  logic                  wen_a,
   input  logic [AW-1:0]         addr_a,
   input  logic [WIDTH-1:0]      data_in_a,
   output logic [WIDTH-1:0]      data_out_a,
   output logic                  stall_a,
   input  logic                  en_b,
   input  logic                  wen_b,
   input  logic [AW-1:0]         addr_b,
   input  logic [WIDTH-1:0]      data_in_b,
   output logic [WIDTH-1:0]      data_out_b,
   input  logic                  snp_valid,
   output logic                  snp_ready,
   input  logic [AW-1:0]         snp_addr,
   input  logic [SNOOP_ID_W-1:0] snp_id,
   output logic                  snp_rsp_valid,
   output logic [AW-1:0]         snp_rsp_addr,
   output logic [SNOOP_ID_W-1:0] snp_rsp_id,
   output logic [WIDTH-1:0]      snp_rsp_data
);

   localparam int RW = AW + SNOOP_ID_W;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  issue;
   logic                  a_acc;
   logic                  a_wr;
   logic [RW-1:0]         head;
   logic [AW-1:0]         head_addr;
   logic [SNOOP_ID_W-1:0] head_id;
   logic [SW-1:0]         starve_cnt;
   logic [AW-1:0]         b1_addr_a;
   logic [WIDTH-1:0]      b1_dout_a;
   logic [WIDTH-1:0]      b1_dout_b_unused;

   // Snoop handshake: a request transfers on a cycle where snp_valid and snp_ready are both high.
   assign snp_ready = ~fifo_full;
   assign push      = snp_valid & ~fifo_full;

   assign stall_a   = (starve_cnt == SW'(STARVE_LIMIT));
   assign a_acc     = en_a & ~stall_a;
   assign a_wr      = a_acc & wen_a;
   assign issue     = ~fifo_empty & ~a_wr;
   assign {head_addr, head_id} = head;
   assign b1_addr_a = a_wr ? addr_a : head_addr;

   snoop_req_fifo #(.W(RW), .DEPTH(SNOOP_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({snp_addr, snp_id}),
      .pop   (issue),
      .head  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   tag_bank #(.W(WIDTH), .LINES(LINES), .AW(AW)) u_bank0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_a   (a_acc),
      .we_a   (wen_a),
      .addr_a (addr_a),
      .din_a  (data_in_a),
      .dout_a (data_out_a),
      .en_b   (en_b),
      .we_b   (wen_b),
      .addr_b (addr_b),
      .din_b  (data_in_b),
      .dout_b (data_out_b)
   );

   // Mirror bank: port A is shared between port-A writes and snoop reads.
   tag_bank #(.W(WIDTH), .LINES(LINES), .AW(AW)) u_bank1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_a   (a_wr | issue),
      .we_a   (a_wr),
      .addr_a (b1_addr_a),
      .din_a  (data_in_a),
      .dout_a (b1_dout_a),
      .en_b   (en_b),
      .we_b   (wen_b),
      .addr_b (addr_b),
      .din_b  (data_in_b),
      .dout_b (b1_dout_b_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (issue || fifo_empty) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snp_rsp_valid <= 1'b0;
         snp_rsp_addr  <= '0;
         snp_rsp_id    <= '0;
      end else begin
         snp_rsp_valid <= issue;
         if (issue) begin
            snp_rsp_addr <= head_addr;
            snp_rsp_id   <= head_id;
         end
      end
   end

   // Bank 1 port A also reads during port-A writes, so hide it outside responses.
   assign snp_rsp_data = snp_rsp_valid ? b1_dout_a : '0;

endmodule

// File: tb/tb_tag_dual_snoop_q.sv
// Self-checking bench for tag_dual_snoop_q: a reference copy of the tag array
// feeds a queue of expected snoop responses, compared as responses appear.
module tb_tag_dual_snoop_q;

   localparam int AW = 9;
   localparam int W  = 32;
   localparam int EW = AW + 2 + W;

   logic          clk;
   logic          rst_n;
   logic          en_a, wen_a, en_b, wen_b;
   logic [AW-1:0] addr_a, addr_b, snp_addr;
   logic [W-1:0]  data_in_a, data_in_b;
   logic [W-1:0]  data_out_a, data_out_b;
   logic          stall_a;
   logic          snp_valid, snp_ready;
   logic [1:0]    snp_id;
   logic          snp_rsp_valid;
   logic [AW-1:0] snp_rsp_addr;
   logic [1:0]    snp_rsp_id;
   logic [W-1:0]  snp_rsp_data;

   int            checks = 0;
   int            errors = 0;
   int            rsp_cnt = 0;
   logic [W-1:0]  model [512];
   logic [EW-1:0] exp_q[$];

   tag_dual_snoop_q dut (
      .clk(clk), .rst_n(rst_n),
      .en_a(en_a), .wen_a(wen_a), .addr_a(addr_a), .data_in_a(data_in_a),
      .data_out_a(data_out_a), .stall_a(stall_a),
      .en_b(en_b), .wen_b(wen_b), .addr_b(addr_b), .data_in_b(data_in_b),
      .data_out_b(data_out_b),
      .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_addr(snp_addr), .snp_id(snp_id),
      .snp_rsp_valid(snp_rsp_valid), .snp_rsp_addr(snp_rsp_addr),
      .snp_rsp_id(snp_rsp_id), .snp_rsp_data(snp_rsp_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: compare each response against the oldest expected entry
   always @(negedge clk) begin
      if (rst_n === 1'b1 && snp_rsp_valid === 1'b1) begin
         logic [EW-1:0] exp_v;
         rsp_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got addr %0d id %0d data %h, expected no response",
                     snp_rsp_addr, snp_rsp_id, snp_rsp_data);
         end else begin
            exp_v = exp_q.pop_front();
            if ({snp_rsp_addr, snp_rsp_id, snp_rsp_data} !== exp_v) begin
               errors++;
               $display("FAIL rsp_match: got addr %0d id %0d data %h, expected addr %0d id %0d data %h",
                        snp_rsp_addr, snp_rsp_id, snp_rsp_data,
                        exp_v[EW-1 -: AW], exp_v[W+1 -: 2], exp_v[W-1:0]);
            end
         end
      end
   end

   // driver: one clock cycle; updates the reference array and expected queue
   task automatic tick(output logic stalled);
      logic acc, a_wr, b_wr;
      stalled = stall_a;
      acc  = snp_valid & snp_ready;
      a_wr = en_a & wen_a & ~stall_a;
      b_wr = en_b & wen_b;
      @(posedge clk);
      if (a_wr) model[addr_a] = data_in_a;
      if (b_wr) model[addr_b] = data_in_b;
      if (acc) exp_q.push_back({snp_addr, snp_id, model[snp_addr]});
      #1;
   endtask

   task automatic idle_inputs();
      en_a = 0; wen_a = 0; en_b = 0; wen_b = 0; snp_valid = 0;
   endtask

   task automatic write_b(input logic [AW-1:0] a, input logic [W-1:0] d);
      logic st;
      en_b = 1; wen_b = 1; addr_b = a; data_in_b = d;
      tick(st);
      en_b = 0; wen_b = 0;
   endtask

   task automatic drain(input string name);
      logic st;
      int n = 0;
      idle_inputs();
      while (exp_q.size() != 0 && n < 64) begin
         tick(st);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      logic st;
      rst_n = 0;
      idle_inputs();
      addr_a = 0; addr_b = 0; snp_addr = 0; snp_id = 0; data_in_a = 0; data_in_b = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({data_out_a, data_out_b, stall_a, snp_rsp_valid, snp_rsp_addr, snp_rsp_id, snp_rsp_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got da %h db %h stall %b rv %b ra %0d ri %0d rd %h, expected all 0",
                  data_out_a, data_out_b, stall_a, snp_rsp_valid, snp_rsp_addr, snp_rsp_id, snp_rsp_data);
      end
      checks++;
      if (snp_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, expected 1", snp_ready);
      end
      rst_n = 1;
      tick(st);
      checks++;
      if (snp_ready !== 1'b1 || snp_rsp_valid !== 1'b0 || stall_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready %b rv %b stall %b, expected 1 0 0", snp_ready, snp_rsp_valid, stall_a);
      end
   endtask

   task automatic test_basic_snoop();
      logic st;
      en_a = 1; wen_a = 1; addr_a = 3; data_in_a = 32'hA5A5_0001;
      tick(st);
      idle_inputs();
      snp_valid = 1; snp_addr = 3; snp_id = 2;
      tick(st);
      snp_valid = 0;
      checks++;
      if (snp_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_rsp: got rsp_valid %b one cycle after accept, expected 0", snp_rsp_valid);
      end
      tick(st);
      checks++;
      if (snp_rsp_valid !== 1'b1 || snp_rsp_id !== 2'd2 || snp_rsp_data !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL basic_rsp: got valid %b id %0d data %h, expected 1 2 a5a50001",
                  snp_rsp_valid, snp_rsp_id, snp_rsp_data);
      end
      en_a = 1; wen_a = 0; addr_a = 3;
      tick(st);
      en_a = 0;
      checks++;
      if (data_out_a !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL basic_read_a: got %h, expected a5a50001", data_out_a);
      end
      drain("basic");
   endtask

   task automatic test_starvation();
      logic st;
      logic [W-1:0] wdata = 32'h3000_0000;
      int first = 0;
      int nstall = 0;
      write_b(20, 32'h2020_2020);
      for (int i = 0; i <= 12; i++) begin
         en_a = 1; wen_a = 1; addr_a = 30; data_in_a = wdata;
         snp_valid = (i == 0); snp_addr = 20; snp_id = 1;
         tick(st);
         if (st) begin
            nstall++;
            if (first == 0) first = i;
            checks++;
            if (snp_rsp_valid !== 1'b1) begin
               errors++;
               $display("FAIL starve_rsp: got rsp_valid %b after stall cycle, expected 1", snp_rsp_valid);
            end
         end else begin
            wdata++;
         end
      end
      snp_valid = 0;
      checks++;
      if (first != 9 || nstall != 1) begin
         errors++;
         $display("FAIL starve_stall: got first stall at cycle %0d with %0d stalls, expected cycle 9 with 1", first, nstall);
      end
      drain("starve");
      en_a = 1; wen_a = 0; addr_a = 30;
      tick(st);
      en_a = 0;
      checks++;
      if (data_out_a !== model[30] || model[30] !== wdata - 1) begin
         errors++;
         $display("FAIL starve_retry: got %h, expected %h", data_out_a, wdata - 1);
      end
   endtask

   task automatic test_fifo_order();
      logic st;
      int base = rsp_cnt;
      for (int k = 1; k <= 4; k++) write_b(AW'(k), $urandom);
      for (int k = 0; k < 7; k++) begin
         en_a = 1; wen_a = 1; addr_a = 40; data_in_a = $urandom;
         snp_valid = (k < 4); snp_addr = AW'(k + 1); snp_id = 2'(k);
         tick(st);
         if (k == 3 || k == 6) begin
            checks++;
            if (snp_ready !== 1'b0) begin
               errors++;
               $display("FAIL fifo_full_ready k=%0d: got %b, expected 0", k, snp_ready);
            end
         end
      end
      drain("fifo");
      checks++;
      if (rsp_cnt - base != 4) begin
         errors++;
         $display("FAIL fifo_count: got %0d responses, expected 4", rsp_cnt - base);
      end
   endtask

   task automatic test_same_cycle();
      logic st;
      en_a = 1; wen_a = 1; addr_a = 7; data_in_a = 32'h5678;
      en_b = 1; wen_b = 1; addr_b = 7; data_in_b = 32'h1234;
      tick(st);
      wen_a = 0; wen_b = 0;
      snp_valid = 1; snp_addr = 7; snp_id = 3;
      tick(st);
      idle_inputs();
      checks++;
      if (data_out_a !== 32'h1234 || data_out_b !== 32'h1234) begin
         errors++;
         $display("FAIL same_cycle_read: got a %h b %h, expected 1234 1234", data_out_a, data_out_b);
      end
      drain("same_cycle");
   endtask

   task automatic test_hazard();
      logic st;
      en_a = 1; wen_a = 1; addr_a = 9; data_in_a = 32'h0909_BEEF;
      snp_valid = 1; snp_addr = 9; snp_id = 0;
      tick(st);
      idle_inputs();
      tick(st);
      checks++;
      if (snp_rsp_valid !== 1'b1 || snp_rsp_data !== 32'h0909_BEEF) begin
         errors++;
         $display("FAIL hazard_rsp: got valid %b data %h, expected 1 0909beef", snp_rsp_valid, snp_rsp_data);
      end
      drain("hazard");
      checks++;
      if (dut.u_bank0.mem[9] !== 32'h0909_BEEF || dut.u_bank1.mem[9] !== 32'h0909_BEEF) begin
         errors++;
         $display("FAIL hazard_backdoor9: got b0 %h b1 %h, expected 0909beef", dut.u_bank0.mem[9], dut.u_bank1.mem[9]);
      end
      checks++;
      if (dut.u_bank0.mem[7] !== 32'h1234 || dut.u_bank1.mem[7] !== 32'h1234) begin
         errors++;
         $display("FAIL hazard_backdoor7: got b0 %h b1 %h, expected 1234", dut.u_bank0.mem[7], dut.u_bank1.mem[7]);
      end
   endtask

   task automatic test_reset_flush();
      logic st;
      int base;
      for (int k = 0; k < 4; k++) begin
         en_a = 1; wen_a = 1; addr_a = 50; data_in_a = 32'(k);
         snp_valid = 1; snp_addr = AW'(k + 1); snp_id = 2'(k);
         tick(st);
      end
      idle_inputs();
      tick(st);
      checks++;
      if (snp_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre_rsp: got %b, expected 1", snp_rsp_valid);
      end
      #1 rst_n = 0;
      #1;
      exp_q.delete();
      base = rsp_cnt;
      checks++;
      if (snp_rsp_valid !== 1'b0 || snp_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_async: got rsp_valid %b ready %b, expected 0 1", snp_rsp_valid, snp_ready);
      end
      @(posedge clk);
      #1 rst_n = 1;
      repeat (10) tick(st);
      checks++;
      if (rsp_cnt != base || snp_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after: got %0d responses ready %b, expected 0 responses ready 1", rsp_cnt - base, snp_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic_snoop();
      test_starvation();
      test_fifo_order();
      test_same_cycle();
      test_hazard();
      test_reset_flush();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
